vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_if.sv | 14 +
 rtl/vga_timing.sv | 65 ++++++
 tb/tb_vga_timing.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 raster timing constants for the timing generator and downstream stages
package vga_pkg;
  typedef logic [10:0] cnt_t;
  localparam int H_VISIBLE     = 800;
  localparam int H_FP          = 40;
  localparam int H_SYNC        = 128;
  localparam int H_BP          = 88;
  localparam int V_VISIBLE     = 600;
  localparam int V_FP          = 1;
  localparam int V_SYNC        = 4;
  localparam int V_BP          = 23;
  localparam int H_TOTAL       = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL       = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START  = H_VISIBLE + H_FP;
  localparam int H_SYNC_END    = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START  = V_VISIBLE + V_FP;
  localparam int V_SYNC_END    = V_SYNC_START + V_SYNC - 1;
  localparam int H_BLANK_START = H_VISIBLE;
  localparam int H_BLANK_END   = H_TOTAL - 1;
  localparam int V_BLANK_START = V_VISIBLE;
  localparam int V_BLANK_END   = V_TOTAL - 1;
  function automatic logic in_span(cnt_t x, cnt_t lo, cnt_t hi);
    return x >= lo && x <= hi;
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel enable in, raster position and sync/blank flags out
interface vga_timing_if;
  import vga_pkg::*;
  logic en;
  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  logic sof;
  modport master(input en, output hcount, vcount, hsync, vsync, hblnk, vblnk, sof);
  modport slave(output en, input hcount, vcount, hsync, vsync, hblnk, vblnk, sof);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered, zero-skew sync/blank flags and start-of-frame pulse
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input logic clk,
  input logic rst,
  vga_timing_if.master bus
);
  localparam cnt_t H_LAST = cnt_t'(H_VIS + H_FRONT + H_SW + H_BACK - 1);
  localparam cnt_t V_LAST = cnt_t'(V_VIS + V_FRONT + V_SW + V_BACK - 1);
  localparam cnt_t H_BS   = cnt_t'(H_VIS);
  localparam cnt_t H_SS   = cnt_t'(H_VIS + H_FRONT);
  localparam cnt_t H_SE   = cnt_t'(H_VIS + H_FRONT + H_SW - 1);
  localparam cnt_t V_BS   = cnt_t'(V_VIS);
  localparam cnt_t V_SS   = cnt_t'(V_VIS + V_FRONT);
  localparam cnt_t V_SE   = cnt_t'(V_VIS + V_FRONT + V_SW - 1);
  cnt_t r_h, r_v, w_h_nxt, w_v_nxt;
  logic w_h_wrap, w_v_wrap;
  logic r_hs, r_vs, r_hb, r_vb, r_sof;
  assign w_h_wrap = r_h == H_LAST;
  assign w_v_wrap = r_v == V_LAST;
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + cnt_t'(1);
  assign w_v_nxt  = !w_h_wrap ? r_v : w_v_wrap ? '0 : r_v + cnt_t'(1);
  // horizontal pixel counter, advancing on enabled cycles
  always_ff @(posedge clk)
    if (rst) r_h <= '0;
    else if (bus.en) r_h <= w_h_nxt;
  // vertical line counter, advancing only when the line wraps
  always_ff @(posedge clk)
    if (rst) r_v <= '0;
    else if (bus.en) r_v <= w_v_nxt;
  // flags decoded from the next counter values so they land in the same cycle as the counters
  always_ff @(posedge clk)
    if (rst) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_hb  <= 1'b0;
      r_vb  <= 1'b0;
      r_sof <= 1'b0;
    end else begin
      r_sof <= bus.en && w_h_wrap && w_v_wrap;
      if (bus.en) begin
        r_hb <= w_h_nxt >= H_BS;
        r_vb <= w_v_nxt >= V_BS;
        r_hs <= in_span(w_h_nxt, H_SS, H_SE);
        r_vs <= in_span(w_v_nxt, V_SS, V_SE);
      end
    end
  assign bus.hcount = r_h;
  assign bus.vcount = r_v;
  assign bus.hsync  = r_hs;
  assign bus.vsync  = r_vs;
  assign bus.hblnk  = r_hb;
  assign bus.vblnk  = r_vb;
  assign bus.sof    = r_sof;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing at full 800x600 and at a reduced geometry
module tb_vga_timing;
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, hb, vb, sof;
  } obs_t;
  localparam int SHV = 16, SHF = 2, SHW = 4, SHB = 3;
  localparam int SVV = 10, SVF = 1, SVW = 2, SVB = 3;
  localparam int S_HT = SHV + SHF + SHW + SHB;
  localparam int S_FR = S_HT * (SVV + SVF + SVW + SVB);
  localparam int F_FR = 1056 * 628;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pf = 0, ps = 0;
  int n_tests = 0, n_fail = 0;
  int sof_s = 0, m_sof_s = 0;
  obs_t qf[$], qs[$];
  vga_timing_if bf();
  vga_timing_if bs();
  vga_timing u_full(.clk(clk), .rst(rst), .bus(bf));
  vga_timing #(
    .H_VIS(SHV), .H_FRONT(SHF), .H_SW(SHW), .H_BACK(SHB),
    .V_VIS(SVV), .V_FRONT(SVF), .V_SW(SVW), .V_BACK(SVB)
  ) u_small(.clk(clk), .rst(rst), .bus(bs));
  initial forever #5 clk = ~clk;
  // raster model: a linear pixel index within the frame, position and flags derived arithmetically
  function automatic obs_t mdl(int p, bit s, int hv, int hfp, int hsw, int hbp, int vv, int vfp, int vsw);
    int ht, h, v;
    obs_t o;
    ht = hv + hfp + hsw + hbp;
    h = p % ht;
    v = p / ht;
    o.h = 11'(h);
    o.v = 11'(v);
    o.hb = h >= hv;
    o.hs = h >= hv + hfp && h < hv + hfp + hsw;
    o.vb = v >= vv;
    o.vs = v >= vv + vfp && v < vv + vfp + vsw;
    o.sof = s;
    return o;
  endfunction
  task automatic step(input bit r, input bit e);
    bit sf, ss;
    rst = r;
    bf.en = e;
    bs.en = e;
    @(posedge clk);
    sf = 1'b0;
    ss = 1'b0;
    if (r) begin
      pf = 0;
      ps = 0;
    end else if (e) begin
      sf = pf == F_FR - 1;
      ss = ps == S_FR - 1;
      pf = (pf + 1) % F_FR;
      ps = (ps + 1) % S_FR;
    end
    m_sof_s += int'(ss);
    qf.push_back(mdl(pf, sf, 800, 40, 128, 88, 600, 1, 4));
    qs.push_back(mdl(ps, ss, SHV, SHF, SHW, SHB, SVV, SVF, SVW));
    #1;
  endtask
  task automatic cmp(input string n, input obs_t e, input obs_t a);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b",
               n, $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.sof, e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.sof);
    end
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", n, a, e);
    end
  endtask
  // monitor: every cycle both instances present a position; pop the expected response and compare
  initial forever begin
    @(negedge clk);
    if (qf.size() > 0)
      cmp("full", qf.pop_front(), {bf.hcount, bf.vcount, bf.hsync, bf.vsync, bf.hblnk, bf.vblnk, bf.sof});
    if (qs.size() > 0) begin
      sof_s += int'(bs.sof === 1'b1);
      cmp("small", qs.pop_front(), {bs.hcount, bs.vcount, bs.hsync, bs.vsync, bs.hblnk, bs.vblnk, bs.sof});
    end
  end
  initial begin
    int hs_rise, hs_fall, hb_rise, c0, m0;
    bit phs, phb;
    repeat (3) step(1'b1, 1'b1);
    chk("rst_h", bf.hcount, 0);
    chk("rst_flags", {bf.hsync, bf.vsync, bf.hblnk, bf.vblnk, bf.sof}, 0);
    repeat (1055) step(1'b0, 1'b1);
    chk("line_end_h", bf.hcount, 1055);
    chk("line_end_hblnk", bf.hblnk, 1);
    step(1'b0, 1'b1);
    chk("line_wrap_h", bf.hcount, 0);
    chk("line_wrap_v", bf.vcount, 1);
    hs_rise = -1;
    hs_fall = -1;
    hb_rise = -1;
    phs = bf.hsync;
    phb = bf.hblnk;
    repeat (1056) begin
      step(1'b0, 1'b1);
      if (bf.hsync && !phs) hs_rise = int'(bf.hcount);
      if (!bf.hsync && phs) hs_fall = int'(bf.hcount);
      if (bf.hblnk && !phb) hb_rise = int'(bf.hcount);
      phs = bf.hsync;
      phb = bf.hblnk;
    end
    chk("hsync_rise", hs_rise, 840);
    chk("hsync_fall", hs_fall, 968);
    chk("hblnk_rise", hb_rise, 800);
    step(1'b1, 1'b1);
    repeat (7 * S_HT + 12) step(1'b0, 1'b1);
    chk("freeze_pre_h", bs.hcount, 12);
    chk("freeze_pre_v", bs.vcount, 7);
    repeat (10) step(1'b0, 1'b0);
    chk("freeze_h", bs.hcount, 12);
    chk("freeze_v", bs.vcount, 7);
    chk("freeze_sof", bs.sof, 0);
    step(1'b0, 1'b1);
    chk("thaw_h", bs.hcount, 13);
    chk("thaw_v", bs.vcount, 7);
    repeat (11 * S_HT + 20 - (7 * S_HT + 13)) step(1'b0, 1'b1);
    chk("midframe_h", bs.hcount, 20);
    chk("midframe_vsync", bs.vsync, 1);
    step(1'b1, 1'b0);
    chk("midrst_pos", {bs.hcount, bs.vcount}, 0);
    chk("midrst_flags", {bs.hsync, bs.vsync, bs.hblnk, bs.vblnk, bs.sof}, 0);
    chk("midrst_full", {bf.hcount, bf.vcount, bf.hsync, bf.vsync, bf.hblnk, bf.vblnk, bf.sof}, 0);
    @(negedge clk);
    #1;
    c0 = sof_s;
    m0 = m_sof_s;
    for (int i = 0; i < 20000 && m_sof_s - m0 < 3; i++) step(1'b0, $urandom_range(0, 3) != 0);
    if (m_sof_s - m0 != 3) begin
      n_fail++;
      $display("FAIL random_frames: bound expired after %0d frame wraps, want 3", m_sof_s - m0);
    end
    repeat (30) step(1'b0, $urandom_range(0, 3) != 0);
    repeat (2) @(negedge clk);
    #1;
    chk("sof_pulses", sof_s - c0, 3);
    chk("queue_drained", qf.size() + qs.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
